// File: rtl/taillight_seq_ctrl.sv
// -----------------------------------------------------------------------------
// taillight_seq_ctrl
//   Front-end controller for the three-lamp taillight sequencer FSM.
//   Synchronises the raw switches, latches them as pending requests,
//   arbitrates them, paces the FSM with a step enable and presents exactly
//   one of L/R/H per sequence. Tracks the sequence phase to know when the
//   FSM re-enters S0 and counts completed sequences.
//
// Parameters
//   DIV       clk cycles per FSM step (>= 2)
//   CW        width of seq_count
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   sw_l/r/h   in   raw left / right / hazard switches (asynchronous)
//   clr        in   synchronous clear of all pending requests
//   step       out  one-cycle FSM clock enable, once every DIV cycles
//   L/R/H      out  request lines to the FSM (one-hot while armed)
//   busy       out  high while a sequence is armed or running
//   grant      out  current sequence type: 0 none, 1 left, 2 right, 3 hazard
//   seq_done   out  pulse on the step where the FSM re-enters S0
//   seq_count  out  completed sequence count, wraps at all-ones
// -----------------------------------------------------------------------------
module taillight_seq_ctrl #(
   parameter int unsigned DIV = 4,
   parameter int unsigned CW  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sw_l,
   input  logic          sw_r,
   input  logic          sw_h,
   input  logic          clr,
   output logic          step,
   output logic          L,
   output logic          R,
   output logic          H,
   output logic          busy,
   output logic [1:0]    grant,
   output logic          seq_done,
   output logic [CW-1:0] seq_count
);

   localparam int unsigned DW = $clog2(DIV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [DW-1:0] r_div;
   logic          w_step;
   logic [2:0]    r_sync1, r_sync2;   // bit0 left, bit1 right, bit2 hazard
   logic [2:0]    r_pend;
   logic [2:0]    w_clr_mask;
   logic [1:0]    r_grant, w_grant_nxt;
   logic [1:0]    r_phase, w_phase_nxt;
   logic          w_seq_done;
   logic [CW-1:0] r_count;

   // Hazard wins, and left+right together is treated as hazard.
   function automatic logic [1:0] f_arb(input logic [2:0] p);
      if (p[2] || (p[0] && p[1])) return 2'd3;
      else if (p[0])              return 2'd1;
      else if (p[1])              return 2'd2;
      else                        return 2'd0;
   endfunction

   // Prescaler
   assign w_step = (r_div == DW'(DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_div <= '0;
      else if (w_step) r_div <= '0;
      else             r_div <= r_div + 1'b1;
   end

   // Two-flop synchronisers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {sw_h, sw_r, sw_l};
         r_sync2 <= r_sync1;
      end
   end

   // Pending flags: clr beats set, set beats the launch clear, so a held
   // switch stays pending across its own launch and repeats.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   r_pend <= '0;
      else if (clr) r_pend <= '0;
      else          r_pend <= r_sync2 | (r_pend & ~w_clr_mask);
   end

   // Sequencer state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_phase_nxt = r_phase;
      w_clr_mask  = '0;
      w_seq_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|r_pend) begin
               w_grant_nxt = f_arb(r_pend);
               w_state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            // Launch: FSM samples S0 -> S1 on this step
            if (w_step) begin
               case (r_grant)
                  2'd1:    w_clr_mask = 3'b001;
                  2'd2:    w_clr_mask = 3'b010;
                  2'd3:    w_clr_mask = 3'b111;
                  default: w_clr_mask = 3'b000;
               endcase
               w_phase_nxt = 2'd1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_step) begin
               if (r_phase == 2'd3) begin
                  // FSM re-enters S0; re-arm immediately if anything waits
                  w_seq_done  = 1'b1;
                  w_phase_nxt = 2'd0;
                  if (|r_pend) begin
                     w_grant_nxt = f_arb(r_pend);
                     w_state_nxt = ST_ARM;
                  end else begin
                     w_grant_nxt = 2'd0;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_phase_nxt = r_phase + 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'd0;
            w_phase_nxt = 2'd0;
         end
      endcase
   end

   // Completed sequence counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_count <= '0;
      else if (w_seq_done) r_count <= r_count + 1'b1;
   end

   assign step      = w_step;
   assign L         = (r_state == ST_ARM) && (r_grant == 2'd1);
   assign R         = (r_state == ST_ARM) && (r_grant == 2'd2);
   assign H         = (r_state == ST_ARM) && (r_grant == 2'd3);
   assign busy      = (r_state != ST_IDLE);
   assign grant     = r_grant;
   assign seq_done  = w_seq_done;
   assign seq_count = r_count;

endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_taillight_seq_ctrl
//   Self-checking bench for taillight_seq_ctrl. A behavioural model tracks
//   time since reset, the switch history through the synchronisers, the
//   pending requests and the position of the current sequence (-1 idle,
//   0 waiting in S0, 1..3 running) and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_taillight_seq_ctrl;

   localparam int unsigned DIV = 4;
   localparam int unsigned CW  = 8;
   localparam int unsigned VW  = 8 + CW;

   logic          clk = 1'b0;
   logic          reset, sw_l, sw_r, sw_h, clr;
   logic          step, L, R, H, busy, seq_done;
   logic [1:0]    grant;
   logic [CW-1:0] seq_count;

   int total = 0;
   int bad   = 0;

   taillight_seq_ctrl #(.DIV(DIV), .CW(CW)) dut (
      .clk(clk), .reset(reset), .sw_l(sw_l), .sw_r(sw_r), .sw_h(sw_h),
      .clr(clr), .step(step), .L(L), .R(R), .H(H), .busy(busy),
      .grant(grant), .seq_done(seq_done), .seq_count(seq_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         m_time;        // cycles since reset release, modulo DIV
   logic [2:0] m_hist[$];     // switch samples still inside the synchronisers
   logic [2:0] m_pend;        // bit0 left, bit1 right, bit2 hazard
   int         m_pos;         // -1 idle, 0 waiting in S0, 1..3 running
   int         m_kind;        // 0 none, 1 left, 2 right, 3 hazard
   int         m_done_cnt;

   function automatic int ref_pick(input logic [2:0] p);
      if (p[2] || (p[0] && p[1])) return 3;
      if (p[0]) return 1;
      if (p[1]) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      m_time = 0;
      m_hist = '{3'b000, 3'b000};
      m_pend = 3'b000;
      m_pos = -1;
      m_kind = 0;
      m_done_cnt = 0;
   endtask

   task automatic model_edge(input logic [2:0] sw, input logic c);
      bit         st;
      logic [2:0] seen, launched, nxt;
      int         pos_n, kind_n;
      st = ((m_time % DIV) == DIV - 1);
      seen = m_hist[0];
      launched = 3'b000;
      if (m_pos == 0 && st)
         launched = (m_kind == 3) ? 3'b111 : (m_kind == 1) ? 3'b001 : 3'b010;
      nxt = c ? 3'b000 : (seen | (m_pend & ~launched));
      pos_n = m_pos;
      kind_n = m_kind;
      if (m_pos < 0) begin
         if (m_pend != 0) begin kind_n = ref_pick(m_pend); pos_n = 0; end
      end else if (st) begin
         if (m_pos == 3) begin
            m_done_cnt = (m_done_cnt + 1) % (1 << CW);
            if (m_pend != 0) begin kind_n = ref_pick(m_pend); pos_n = 0; end
            else begin kind_n = 0; pos_n = -1; end
         end else begin
            pos_n = m_pos + 1;
         end
      end
      m_pend = nxt;
      m_pos = pos_n;
      m_kind = kind_n;
      m_time = (m_time + 1) % DIV;
      void'(m_hist.pop_front());
      m_hist.push_back(sw);
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic st;
      st = ((m_time % DIV) == DIV - 1);
      return {st, (m_pos == 0 && m_kind == 1), (m_pos == 0 && m_kind == 2),
              (m_pos == 0 && m_kind == 3), (m_pos >= 0), 2'(m_kind),
              (m_pos == 3 && st), CW'(m_done_cnt)};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {step, L, R, H, busy, grant, seq_done, seq_count};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic l, input logic r, input logic h, input logic c);
      @(negedge clk);
      sw_l = l; sw_r = r; sw_h = h; clr = c;
      model_edge({h, r, l}, c);
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      sw_l = 0; sw_r = 0; sw_h = 0; clr = 0;
      reset = 1'b1;
      model_edge(3'b000, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      sw_l = 0; sw_r = 0; sw_h = 0; clr = 0;
      reset = 1'b0;
      model_reset();
      #1;
      release_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sw_l = 0; sw_r = 0; sw_h = 0; clr = 0;
      reset = 1'b0;
      model_reset();
      #12;
      total++;
      if (obs_vec() !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want %h", obs_vec(), {VW{1'b0}});
      end
      release_reset();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_prescaler: got %h want %h", obs_vec(), exp_vec());
         end
         tick(0, 0, 0, 0);
      end
   endtask

   task automatic test_single_left();
      apply_reset();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 30; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_left: got %h want %h", obs_vec(), exp_vec());
         end
         tick(0, 0, 0, 0);
      end
      total++;
      if (seq_count !== CW'(1) || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_left_end: got count=%0d busy=%b want count=1 busy=0",
                  seq_count, busy);
      end
   endtask

   task automatic test_simultaneous();
      bit saw_h, saw_lr;
      saw_h = 0; saw_lr = 0;
      apply_reset();
      tick(1, 1, 0, 0);
      for (int i = 0; i < 30; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL simultaneous: got %h want %h", obs_vec(), exp_vec());
         end
         if (H) saw_h = 1;
         if (L || R) saw_lr = 1;
         tick(0, 0, 0, 0);
      end
      total++;
      if (!saw_h || saw_lr || seq_count !== CW'(1)) begin
         bad++;
         $display("FAIL simultaneous_hazard: got sawH=%b sawLR=%b count=%0d want 1 0 1",
                  saw_h, saw_lr, seq_count);
      end
   endtask

   task automatic test_held_right();
      apply_reset();
      for (int i = 0; i < 30; i++) begin
         tick(0, 1, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL held_right: got %h want %h", obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 50; i++) begin
         tick(0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL held_right_tail: got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_request_during_run();
      int  budget;
      bit  prev_done, checked;
      apply_reset();
      tick(1, 0, 0, 0);
      budget = 0;
      while (m_pos != 2 && budget < 40) begin
         tick(0, 0, 0, 0);
         budget++;
      end
      total++;
      if (m_pos != 2) begin
         bad++;
         $display("FAIL run_request_timeout: got pos=%0d want 2", m_pos);
      end
      tick(0, 1, 0, 0);
      prev_done = 0; checked = 0;
      for (int i = 0; i < 40; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL run_request: got %h want %h", obs_vec(), exp_vec());
         end
         if (prev_done && !checked) begin
            checked = 1;
            total++;
            if (R !== 1'b1 || grant !== 2'd2) begin
               bad++;
               $display("FAIL run_request_b2b: got R=%b grant=%0d want R=1 grant=2", R, grant);
            end
         end
         prev_done = seq_done;
         tick(0, 0, 0, 0);
      end
   endtask

   task automatic test_clr_during_run();
      int budget;
      apply_reset();
      tick(1, 0, 0, 0);
      budget = 0;
      while (m_pos != 1 && budget < 40) begin
         tick(0, 0, 0, 0);
         budget++;
      end
      tick(0, 1, 0, 0);
      repeat (4) tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL clr_run: got %h want %h", obs_vec(), exp_vec());
         end
         tick(0, 0, 0, 0);
      end
      total++;
      if (seq_count !== CW'(1) || busy !== 1'b0) begin
         bad++;
         $display("FAIL clr_run_end: got count=%0d busy=%b want count=1 busy=0",
                  seq_count, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int budget;
      apply_reset();
      tick(1, 0, 0, 0);
      budget = 0;
      while (m_pos != 2 && budget < 40) begin
         tick(0, 0, 0, 0);
         budget++;
      end
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs_vec() !== '0) begin
         bad++;
         $display("FAIL reset_mid_run: got %h want %h", obs_vec(), {VW{1'b0}});
      end
      release_reset();
      for (int i = 0; i < 20; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_run_after: got %h want %h", obs_vec(), exp_vec());
         end
         tick(0, 0, 0, 0);
      end
   endtask

   task automatic test_random();
      logic l, r, h, c;
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         l = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 19) == 0);
         h = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 59) == 0);
         tick(l, r, h, c);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random: got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [CW-1:0] prev;
      bit            saw_wrap;
      apply_reset();
      prev = '0;
      saw_wrap = 0;
      for (int i = 0; i < 4400; i++) begin
         tick(0, 0, 1, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL wrap: got %h want %h", obs_vec(), exp_vec());
         end
         if (prev == {CW{1'b1}} && seq_count == '0) saw_wrap = 1;
         prev = seq_count;
      end
      total++;
      if (!saw_wrap) begin
         bad++;
         $display("FAIL wrap_seen: got %b want 1", saw_wrap);
      end
   endtask

   initial begin
      test_reset();
      test_single_left();
      test_simultaneous();
      test_held_right();
      test_request_during_run();
      test_clr_during_run();
      test_reset_mid_run();
      test_random();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
